// File: rtl/lfsr_rng_arbiter.sv
// Round-robin arbiter that hands out words from one shared 32-bit LFSR.
// It also sequences seed loading and warm-up through the generator's
// synchronous reset/seed pins. Every grant captures the generator output
// of that cycle, and at most one grant is issued per cycle, so each
// consumer receives a distinct draw.
//
// state | meaning
// LOAD  | lfsr_reset high, generator loads lfsr_seed at the next edge
// WARM  | discarding generator outputs, warm_cnt counts down to 0
// RUN   | ready high, one grant per cycle to the round-robin winner
module lfsr_rng_arbiter #(
  parameter int          N_REQ         = 4,
  parameter int          WARMUP_CYCLES = 32,
  parameter logic [31:0] SEED_DEFAULT  = 32'hAAAA_AAAA,
  localparam int         GW            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic [31:0]      rnd_out,
  output logic [GW-1:0]    gnt_id,
  output logic             ready,
  input  logic             reseed,
  input  logic [31:0]      seed_in,
  output logic             lfsr_reset,
  output logic [31:0]      lfsr_seed,
  input  logic [31:0]      lfsr_rnd
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Counter reload value; with no warm-up the counter is never used.
  localparam logic [15:0] WARM_LOAD =
    (WARMUP_CYCLES == 0) ? 16'd0 : 16'(WARMUP_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [15:0]      warm_cnt;
  logic [GW-1:0]    rr;
  logic [GW-1:0]    win;
  logic [GW-1:0]    rr_nxt;
  logic             found;
  logic [N_REQ-1:0] eligible;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_LOAD;
    else          state <= state_nxt;
  end

  // Next-state logic; a reseed request overrides every state.
  always_comb begin
    state_nxt = state;
    if (reseed) begin
      state_nxt = ST_LOAD;
    end else begin
      case (state)
        ST_LOAD: state_nxt = (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARM;
        ST_WARM: if (warm_cnt == 16'd0) state_nxt = ST_RUN;
        ST_RUN:  state_nxt = ST_RUN;
        default: state_nxt = ST_LOAD;
      endcase
    end
  end

  // Moore outputs: generator held in reset only during LOAD.
  always_comb begin
    ready      = (state == ST_RUN);
    lfsr_reset = (state == ST_LOAD);
  end

  // Warm-up down-counter, reloaded on every exit from LOAD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      warm_cnt <= 16'd0;
    else if (state == ST_LOAD && !reseed)
      warm_cnt <= WARM_LOAD;
    else if (state == ST_WARM && warm_cnt != 16'd0)
      warm_cnt <= warm_cnt - 16'd1;
  end

  // Seed latch; a zero seed would lock the LFSR, so substitute the default.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      lfsr_seed <= SEED_DEFAULT;
    else if (reseed)
      lfsr_seed <= (seed_in == 32'd0) ? SEED_DEFAULT : seed_in;
  end

  // Round-robin search from rr; a requester acked this cycle sits out one cycle.
  always_comb begin
    logic [GW:0]   sum;
    logic [GW-1:0] cand;
    eligible = req & ~ack;
    found    = 1'b0;
    win      = '0;
    sum      = '0;
    cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, rr} + (GW+1)'(i);
      if (sum >= (GW+1)'(N_REQ)) sum = sum - (GW+1)'(N_REQ);
      cand = sum[GW-1:0];
      if (!found && eligible[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    rr_nxt = (win == GW'(N_REQ - 1)) ? '0 : win + GW'(1);
  end

  // Grant register: one-cycle ack pulse with the word sampled this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack     <= '0;
      rnd_out <= 32'd0;
      gnt_id  <= '0;
      rr      <= '0;
    end else if (state == ST_RUN && !reseed && found) begin
      ack     <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
      gnt_id  <= win;
      rnd_out <= lfsr_rnd;
      rr      <= rr_nxt;
    end else begin
      ack <= '0;
    end
  end

endmodule
